// File: rtl/cu_instr_sequencer.sv
// Steps a small stored program onto the CU instruction bus, one word at a time.
// After each word has been held for HOLD cycles, it captures the CU result.
module cu_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [18:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [18:0]   instruction,
  input  logic [7:0]    cu_result,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [2:0]    res_op,
  output logic [AW-1:0] res_index,
  output logic          busy,
  output logic          done
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [18:0]   instruction_q, instruction_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_op_q, res_op_d;
  logic [AW-1:0] res_index_q, res_index_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW:0]   len_clamp;
  logic [AW:0]   nxt;

  assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    instruction_d = instruction_q;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_op_d      = res_op_q;
    res_index_d   = res_index_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    nxt           = {1'b0, pc_q} + (AW + 1)'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len_clamp;
          if ((len_clamp == '0) || (mem_q[0][18:16] == 3'b000)) begin
            done_d = 1'b1;
          end else begin
            instruction_d = mem_q[0];
            pc_d          = '0;
            cnt_d         = CNT_INIT;
            busy_d        = 1'b1;
            state_d       = RUN;
          end
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_data_d  = cu_result;
          res_op_d    = instruction_q[18:16];
          res_index_d = pc_q;
          res_valid_d = 1'b1;
          // nxt==len is tested first so mem is never consulted past the run.
          if ((nxt == len_q) || (mem_q[nxt[AW-1:0]][18:16] == 3'b000)) begin
            done_d        = 1'b1;
            busy_d        = 1'b0;
            instruction_d = '0;
            state_d       = IDLE;
          end else begin
            pc_d          = nxt[AW-1:0];
            instruction_d = mem_q[nxt[AW-1:0]];
            cnt_d         = CNT_INIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      instruction_q <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
      res_index_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      instruction_q <= instruction_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_op_q      <= res_op_d;
      res_index_q   <= res_index_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign instruction = instruction_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_op      = res_op_q;
  assign res_index   = res_index_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cu_instr_sequencer.sv
// Bench for cu_instr_sequencer: HOLD=2 and HOLD=1 instances against a program-level model.
module tb_cu_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          wr_s = 1'b0, wr_all = 1'b0, start_s = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [18:0]   wr_data = '0;
  logic [AW:0]   prog_len = '0;
  int            sel_h = 2;

  logic          wr_en1, start1, rv1, busy1, done1;
  logic [18:0]   instr1;
  logic [7:0]    cu1, rd1;
  logic [2:0]    rop1;
  logic [AW-1:0] ridx1;
  logic          wr_en2, start2, rv2, busy2, done2;
  logic [18:0]   instr2;
  logic [7:0]    cu2, rd2;
  logic [2:0]    rop2;
  logic [AW-1:0] ridx2;

  int checks = 0;
  int errors = 0;
  logic [18:0] mem1 [DEPTH];
  logic [18:0] mem2 [DEPTH];

  function automatic logic [7:0] cu_fn(input logic [18:0] w);
    logic [7:0] a, b;
    a = w[15:8];
    b = w[7:0];
    case (w[18:16])
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return {a[6:0], 1'b0};
      3'd7: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign cu1 = cu_fn(instr1);
  assign cu2 = cu_fn(instr2);
  assign start1 = start_s && (sel_h == 1);
  assign start2 = start_s && (sel_h == 2);
  assign wr_en1 = wr_s && (wr_all || sel_h == 1);
  assign wr_en2 = wr_s && (wr_all || sel_h == 2);

  logic          s_rv, s_busy, s_done;
  logic [18:0]   s_instr;
  logic [7:0]    s_rd;
  logic [2:0]    s_rop;
  logic [AW-1:0] s_ridx;
  assign s_rv    = (sel_h == 1) ? rv1 : rv2;
  assign s_busy  = (sel_h == 1) ? busy1 : busy2;
  assign s_done  = (sel_h == 1) ? done1 : done2;
  assign s_instr = (sel_h == 1) ? instr1 : instr2;
  assign s_rd    = (sel_h == 1) ? rd1 : rd2;
  assign s_rop   = (sel_h == 1) ? rop1 : rop2;
  assign s_ridx  = (sel_h == 1) ? ridx1 : ridx2;

  cu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start1), .instruction(instr1), .cu_result(cu1),
    .res_valid(rv1), .res_data(rd1), .res_op(rop1), .res_index(ridx1),
    .busy(busy1), .done(done1));

  cu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start2), .instruction(instr2), .cu_result(cu2),
    .res_valid(rv2), .res_data(rd2), .res_op(rop2), .res_index(ridx2),
    .busy(busy2), .done(done2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [18:0] data);
    @(negedge clk);
    wr_all  = 1'b1;
    wr_s    = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_s   = 1'b0;
    wr_all = 1'b0;
    mem1[addr] = data;
    mem2[addr] = data;
  endtask

  task automatic load_base();
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 7) write_word(k, {3'(k + 1), 8'h23, 8'h14});
      else       write_word(k, {3'((k % 7) + 1), 8'(k * 13), 8'(k * 7 + 1)});
    end
  endtask

  // Model: the run is the prefix of the program up to the clamped length or
  // the first halt word; word k is on the bus for cycles [k*h, (k+1)*h) after
  // start and its result is reported at cycle (k+1)*h.
  task automatic run_prog(input int h, input int len, input bit disturb,
                          input bit chain_in, input bit chain_out, output int n_rv);
    logic [18:0] exp_w[$];
    logic [18:0] m [DEPTH];
    logic [18:0] prev;
    int n, lim, k;
    bit exp_rv;
    sel_h = h;
    if (h == 1) m = mem1; else m = mem2;
    lim = (len > DEPTH) ? DEPTH : len;
    exp_w.delete();
    for (int j = 0; j < lim; j++) begin
      if (m[j][18:16] == 3'b000) break;
      exp_w.push_back(m[j]);
    end
    n = exp_w.size();
    prog_len = (AW + 1)'(len);
    if (!chain_in) begin
      @(negedge clk);
      start_s = 1'b1;
    end
    @(negedge clk);
    start_s = 1'b0;
    n_rv = 0;
    prev = '0;
    for (int t = 0; t <= n * h + 3; t++) begin
      if (t > 0) @(negedge clk);
      exp_rv = (t >= h) && (t % h == 0) && (t / h <= n);
      chk("busy", 32'(s_busy), 32'(t < n * h));
      chk("instruction", 32'(s_instr), (t < n * h) ? 32'(exp_w[t / h]) : 32'h0);
      chk("res_valid", 32'(s_rv), 32'(exp_rv));
      chk("done", 32'(s_done), 32'(t == n * h));
      if (s_rv) n_rv++;
      if (exp_rv) begin
        k = t / h - 1;
        chk("res_index", 32'(s_ridx), 32'(k));
        chk("res_op", 32'(s_rop), 32'(exp_w[k][18:16]));
        chk("res_data", 32'(s_rd), 32'(cu_fn(exp_w[k])));
        chk("res_data_vs_prev_instr", 32'(s_rd), 32'(cu_fn(prev)));
      end
      if (disturb && t == 3) begin
        start_s = 1'b1;
        wr_s    = 1'b1;
        wr_addr = AW'(5);
        wr_data = 19'h0;
      end else if (disturb && t == 4) begin
        start_s = 1'b0;
        wr_s    = 1'b0;
      end
      if (chain_out && t == n * h) begin
        start_s = 1'b1;
        break;
      end
      prev = s_instr;
    end
  endtask

  typedef struct {
    int          ov_idx;
    logic [18:0] ov_word;
    int          len;
    int          exp_n;
  } vec_t;

  vec_t tbl [8];
  int n_rv;

  initial begin
    tbl[0] = '{-1, 19'h0,     7,  7};
    tbl[1] = '{ 3, 19'h0,     7,  3};
    tbl[2] = '{-1, 19'h0,     0,  0};
    tbl[3] = '{ 0, 19'h0,     7,  0};
    tbl[4] = '{-1, 19'h0,     16, 16};
    tbl[5] = '{-1, 19'h0,     31, 16};
    tbl[6] = '{ 6, 19'h0ABCD, 16, 6};
    tbl[7] = '{ 5, 19'h70000, 8,  8};

    repeat (3) @(negedge clk);
    chk("rst_instruction", 32'(instr2), 32'h0);
    chk("rst_res_valid", 32'(rv2), 32'h0);
    chk("rst_busy", 32'({busy1, busy2}), 32'h0);
    chk("rst_done", 32'({done1, done2}), 32'h0);
    chk("rst_res_fields", 32'({rd2, rop2, ridx2}), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_base();
      if (tbl[i].ov_idx >= 0) write_word(tbl[i].ov_idx, tbl[i].ov_word);
      for (int h = 2; h >= 1; h--) begin
        run_prog(h, tbl[i].len, 1'b0, 1'b0, 1'b0, n_rv);
        chk($sformatf("vec%0d_h%0d_count", i, h), 32'(n_rv), 32'(tbl[i].exp_n));
      end
    end

    // Mid-run start and write must be ignored; start in the done cycle chains a new run.
    load_base();
    run_prog(2, 7, 1'b1, 1'b0, 1'b1, n_rv);
    chk("disturb_count", 32'(n_rv), 32'd7);
    run_prog(2, 7, 1'b0, 1'b1, 1'b0, n_rv);
    chk("chained_count", 32'(n_rv), 32'd7);

    // Reset during instruction 2 abandons the run.
    sel_h = 2;
    prog_len = 5'd7;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_instruction", 32'(instr2), 32'(mem2[2]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_outputs", 32'({instr2, rv2, busy2, done2}), 32'h0);
    chk("midrun_rst_res", 32'({rd2, rop2, ridx2}), 32'h0);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'({busy2, done2, rv2}), 32'h0);
    end
    run_prog(2, 7, 1'b0, 1'b0, 1'b0, n_rv);
    chk("replay_count", 32'(n_rv), 32'd7);

    // Randomized programs and lengths against the model.
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 4; w++) begin
        write_word(int'($urandom_range(0, DEPTH - 1)), 19'($urandom));
      end
      run_prog(int'($urandom_range(1, 2)), int'($urandom_range(0, 20)), 1'b0, 1'b0, 1'b0, n_rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_instr_sequencer.md
Name: cu_instr_sequencer

Overview:
Initiator side of the 19-bit CU instruction interface. It holds a small program of instruction words, drives them one at a time onto the CU `instruction` input, and samples the 8-bit CU `result` after a fixed settle time. It returns each result with its index and opcode. It sits between a host or loader and the combinational CU, and replaces hand-driven instruction stimulus in system-level runs.

Parameters:
- DEPTH, 16: number of program slots.
- AW, 4: slot address width; must satisfy 2**AW >= DEPTH.
- HOLD, 2: cycles each instruction is held stable before its result is sampled; minimum value 1.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- wr_en, input, 1: program write strobe.
- wr_addr, input, AW: program slot to write.
- wr_data, input, 19: instruction word. Fields are {op[18:16], a[15:8], b[7:0]}.
- prog_len, input, AW+1: number of slots to run, 0..DEPTH. Sampled with start.
- start, input, 1: begin a run from slot 0.
- instruction, output, 19: instruction driven to the CU.
- cu_result, input, 8: result returned by the CU.
- res_valid, output, 1: one-cycle pulse; a result is present.
- res_data, output, 8: captured `cu_result`.
- res_op, output, 3: opcode of the captured instruction.
- res_index, output, AW: slot index of the captured instruction.
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle pulse at the end of a run.

Behaviour:
- Reset (synchronous, active-high):
  - instruction=0, res_valid=0, res_data=0, res_op=0, res_index=0, busy=0, done=0.
  - pc=0, hold counter=0, state=IDLE.
  - Program memory is not cleared; its contents survive reset.
- Writes:
  - When wr_en=1 and busy=0, mem[wr_addr]<=wr_data.
  - A write while busy=1 is ignored.
  - A write to wr_addr >= DEPTH is ignored.
- Halt opcode: op==3'b000 is a halt marker. It is never driven to the CU and ends the run.
- States are IDLE and RUN.
- IDLE:
  - start=1 is sampled at edge E0. prog_len is latched at E0 and clamped to DEPTH.
  - If the latched length is 0, or mem[0].op==000: at E0 done<=1 for one cycle, busy stays 0, state stays IDLE.
  - Otherwise, at E0: instruction<=mem[0], pc<=0, cnt<=HOLD-1, busy<=1, state<=RUN.
- RUN:
  - On each edge with cnt!=0: cnt<=cnt-1, and instruction is held.
  - On the edge with cnt==0 (the capture edge):
    - res_data<=cu_result, res_op<=instruction[18:16], res_index<=pc, res_valid<=1.
    - Let nxt=pc+1.
    - If nxt==len, or mem[nxt].op==000: done<=1, busy<=0, instruction<=0, state<=IDLE.
    - Otherwise: pc<=nxt, instruction<=mem[nxt], cnt<=HOLD-1.
- Timing:
  - Each instruction is stable for exactly HOLD cycles.
  - Instruction k is driven after edge E0+k*HOLD.
  - Its res_valid is high in the cycle after edge E0+(k+1)*HOLD.
  - On the final instruction, done and res_valid pulse in the same cycle.
  - Throughput is one result per HOLD cycles. With HOLD=1, results arrive on consecutive cycles.
- Starts:
  - start while busy=1 is ignored.
  - start in the same cycle as done is honoured, because state is IDLE at that edge.
- Reset while running: the run is abandoned. Outputs go to reset values on that edge and no done pulse is produced.
- res_data, res_op and res_index hold their values until the next capture edge. Only res_valid pulses.

Test Plan:
1. Load the 7 words {op=001..111, a=0x23, b=0x14} into slots 0-6, prog_len=7, HOLD=2, with a CU model attached.
   - Expect 7 res_valid pulses spaced 2 cycles apart.
   - Expect res_index 0..6 and res_op 1..7.
   - Expect res_data equal to the model output for each word.
   - Expect done coincident with the 7th pulse, and busy high for exactly 14 cycles.
2. Program as in test 1 with slot 3 = 19'h0, prog_len=7.
   - Expect exactly 3 results (index 0-2), with done on the 3rd.
   - instruction must never equal an op=000 word while busy.
3. prog_len=0, and separately mem[0]=19'h0.
   - Expect a done pulse in the cycle after start, res_valid never asserted, busy never asserted.
4. Pulse start and wr_en (to slot 5) mid-run.
   - Expect no restart and mem[5] unchanged.
   - Then assert start in the done cycle: expect a second run to begin immediately.
5. Assert rst during instruction 2 of a 7-word run.
   - Expect all outputs 0 on the next cycle and no done pulse.
   - A new start replays from slot 0 with the memory intact.
6. Run with HOLD=1.
   - Expect res_valid high on 7 consecutive cycles.
   - Expect each res_data to match the word that was driven in the preceding cycle.
